// File: rtl/regbank_scheduler.sv
// Register-bank port owner: clears the bank after reset or on request, then arbitrates
// writeback, PC update and debug reads onto the single write port and the user read port.
module regbank_scheduler #(
  parameter int NREG       = 16,
  parameter int AW         = 4,
  parameter int DW         = 16,
  parameter int PC_IDX     = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          wb_gnt,
  input  logic          pc_req,
  input  logic [DW-1:0] pc_data,
  output logic          pc_gnt,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_reg,
  output logic          dbg_gnt,
  output logic          dbg_valid,
  output logic [DW-1:0] dbg_data,
  input  logic [DW-1:0] user_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_reg,
  output logic [DW-1:0] wr_data,
  output logic          pc_inc,
  output logic [DW-1:0] pc_data_in,
  output logic [AW-1:0] user_in
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  // Handshake: a transfer happens at the rising edge where req && gnt are both high;
  // a requester holds req and its payload stable until it sees gnt. Grants are combinational.

  typedef enum logic {S_CLEAR, S_RUN} main_state_t;
  typedef enum logic [1:0] {D_IDLE, D_ADDR, D_WAIT} dbg_state_t;

  // State kept as plain named signals so checkers can bind to them directly.
  main_state_t   main_state;
  dbg_state_t    dbg_state;
  logic [AW-1:0] idx;
  logic [SW-1:0] starve;

  logic run_open;
  logic pc_forced;

  assign busy      = (main_state == S_CLEAR);
  // A clear request in RUN pre-empts every requester in that same cycle.
  assign run_open  = (main_state == S_RUN) && !clr_req;
  assign pc_forced = (starve == SW'(STARVE_MAX)) && pc_req;
  assign wb_gnt    = run_open && wb_req && !pc_forced;
  assign pc_gnt    = run_open && pc_req && (pc_forced || !wb_req);
  assign dbg_gnt   = run_open && dbg_req && (dbg_state == D_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_state <= S_CLEAR;
      idx        <= '0;
      starve     <= '0;
      wr_en      <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
      pc_inc     <= 1'b0;
      pc_data_in <= '0;
    end else begin
      if (pc_gnt)
        starve <= '0;
      else if (pc_req && (starve != SW'(STARVE_MAX)))
        starve <= starve + 1'b1;

      case (main_state)
        S_CLEAR: begin
          wr_en   <= 1'b1;
          wr_reg  <= idx;
          wr_data <= '0;
          pc_inc  <= 1'b0;
          idx     <= idx + 1'b1;
          if (idx == AW'(NREG - 1)) begin
            main_state <= S_RUN;
            idx        <= '0;
          end
        end
        default: begin
          wr_en  <= wb_gnt;
          pc_inc <= pc_gnt;
          if (wb_gnt) begin
            wr_reg  <= wb_reg;
            wr_data <= wb_data;
          end
          if (pc_gnt)
            pc_data_in <= pc_data;
          if (clr_req) begin
            main_state <= S_CLEAR;
            idx        <= '0;
          end
        end
      endcase
    end
  end

  // Read pipeline: index out at T, bank samples at T+1, capture its result at T+2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dbg_state <= D_IDLE;
      dbg_valid <= 1'b0;
      dbg_data  <= '0;
      user_in   <= '0;
    end else begin
      dbg_valid <= 1'b0;
      case (dbg_state)
        D_IDLE: begin
          if (dbg_gnt) begin
            user_in   <= dbg_reg;
            dbg_state <= D_ADDR;
          end
        end
        D_ADDR: dbg_state <= D_WAIT;
        D_WAIT: begin
          dbg_data  <= user_out;
          dbg_valid <= 1'b1;
          dbg_state <= D_IDLE;
        end
        default: dbg_state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_scheduler.sv
// Directed bench for regbank_scheduler with a small behavioural model of the register bank.
module tb_regbank_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        busy;
  logic        wb_req;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        wb_gnt;
  logic        pc_req;
  logic [15:0] pc_data;
  logic        pc_gnt;
  logic        dbg_req;
  logic [3:0]  dbg_reg;
  logic        dbg_gnt;
  logic        dbg_valid;
  logic [15:0] dbg_data;
  logic [15:0] user_out;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        pc_inc;
  logic [15:0] pc_data_in;
  logic [3:0]  user_in;

  int n_cmp = 0;
  int n_err = 0;

  regbank_scheduler dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
    .wb_req(wb_req), .wb_reg(wb_reg), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .pc_req(pc_req), .pc_data(pc_data), .pc_gnt(pc_gnt),
    .dbg_req(dbg_req), .dbg_reg(dbg_reg), .dbg_gnt(dbg_gnt),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .user_out(user_out),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .pc_inc(pc_inc), .pc_data_in(pc_data_in), .user_in(user_in)
  );

  // clock / bank model
  always #5 clk = ~clk;

  logic [15:0] bank [16];
  always @(posedge clk) begin
    if (wr_en) bank[wr_reg] <= wr_data;
    else if (pc_inc) bank[0] <= pc_data_in;
    user_out <= (wr_en && wr_reg == user_in) ? wr_data : bank[user_in];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; clr_req = 1'b0;
    wb_req = 1'b0; wb_reg = '0; wb_data = '0;
    pc_req = 1'b0; pc_data = '0;
    dbg_req = 1'b0; dbg_reg = '0;

    // 1) reset and initial sweep
    tick(); tick();
    check("rst_busy", busy, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_reg", wr_reg, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_dbg_valid", dbg_valid, 0);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("sweep_wr_en", wr_en, 1);
      check("sweep_wr_reg", wr_reg, i);
      check("sweep_wr_data", wr_data, 0);
      check("sweep_busy", busy, (i == 15) ? 0 : 1);
    end
    tick();
    check("idle_wr_en", wr_en, 0);

    // 2) lone writeback
    wb_req = 1'b1; wb_reg = 4'd5; wb_data = 16'h1234;
    #1 check("wb_gnt", wb_gnt, 1);
    tick();
    wb_req = 1'b0;
    check("wb_wr_en", wr_en, 1);
    check("wb_wr_reg", wr_reg, 5);
    check("wb_wr_data", wr_data, 16'h1234);
    check("wb_pc_inc", pc_inc, 0);
    tick();
    check("hold_wr_en", wr_en, 0);
    check("hold_wr_reg", wr_reg, 5);

    // 3) starvation: three wb wins, then pc
    wb_req = 1'b1; wb_reg = 4'd3; wb_data = 16'haaaa;
    pc_req = 1'b1; pc_data = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("starve_wb_gnt", wb_gnt, (k < 3) ? 1 : 0);
      check("starve_pc_gnt", pc_gnt, (k == 3) ? 1 : 0);
      tick();
      if (k == 3) begin
        wb_req = 1'b0; pc_req = 1'b0;
      end
      check("starve_wr_en", wr_en, (k < 3) ? 1 : 0);
      check("starve_pc_inc", pc_inc, (k == 3) ? 1 : 0);
    end
    check("pc_data_in", pc_data_in, 16'h0100);
    check("pc_wr_data_hold", wr_data, 16'haaaa);

    // 4) write then debug read of the same register
    wb_req = 1'b1; wb_reg = 4'd4; wb_data = 16'h0014;
    #1 check("wb4_gnt", wb_gnt, 1);
    tick();
    wb_req = 1'b0;
    dbg_req = 1'b1; dbg_reg = 4'd4;
    #1 check("dbg_gnt", dbg_gnt, 1);
    tick();
    dbg_req = 1'b0;
    check("dbg_user_in", user_in, 4);
    check("dbg_valid_t0", dbg_valid, 0);
    #1 check("dbg_gnt_busy", dbg_gnt, 0);
    tick();
    check("dbg_valid_t1", dbg_valid, 0);
    tick();
    check("dbg_valid_t2", dbg_valid, 1);
    check("dbg_data", dbg_data, 16'h0014);
    tick();
    check("dbg_valid_pulse", dbg_valid, 0);

    // 5) clear request beats a held writeback
    wb_req = 1'b1; wb_reg = 4'd7; wb_data = 16'h7777; clr_req = 1'b1;
    #1 check("clr_wb_gnt", wb_gnt, 0);
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clr_hold_gnt", wb_gnt, 0);
      check("clr_busy", busy, 1);
      tick();
    end
    check("clr_run_gnt", wb_gnt, 1);
    check("clr_run_busy", busy, 0);
    tick();
    wb_req = 1'b0;
    check("clr_wb_wr_reg", wr_reg, 7);
    check("clr_wb_wr_data", wr_data, 16'h7777);

    // 6) reset mid-sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_wr_reg", wr_reg, 7);
    rst = 1'b0;
    tick();
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_wr_reg", wr_reg, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_pc_data_in", pc_data_in, 0);
    check("mid_rst_dbg_data", dbg_data, 0);
    check("mid_rst_user_in", user_in, 0);
    check("mid_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    check("restart_wr_en", wr_en, 1);
    check("restart_wr_reg", wr_reg, 0);
    for (int i = 0; i < 15; i++) tick();
    check("restart_end_reg", wr_reg, 15);
    check("restart_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
